// File: rtl/tail_pkg.sv
// Shared mode encoding for the turn-signal lab: controller FSM, tail-light
// sequencer and the seven-segment path all agree on these codes.
package tail_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_IDLE   = 3'd0;
  localparam mode_t MODE_HAZARD = 3'd1;
  localparam mode_t MODE_LEFT   = 3'd2;
  localparam mode_t MODE_RIGHT  = 3'd3;

  // Codes 4..7 are unassigned and fold onto IDLE.
  function automatic mode_t eff_mode(input mode_t m);
    return (m > MODE_RIGHT) ? MODE_IDLE : m;
  endfunction

endpackage

// File: rtl/tail_light_sequencer_tick_div.sv
// Step-rate prescaler: one-cycle tick every TICK_DIV clocks, restartable
// from zero by a synchronous clear.
module tick_div #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      div_cnt <= '0;
    else if (clr || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: idle / hazard / left sweep / right sweep on two LED
// banks. Optional brake overlay enabled by defining TAIL_BRAKE_EN.
module tail_light_sequencer
  import tail_pkg::*;
#(
  parameter int LEDS     = 3,
  parameter int TICK_DIV = 1,
  parameter int FILL     = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  mode_t           mode,
`ifdef TAIL_BRAKE_EN
  input  logic            brake,
`endif
  output logic [LEDS-1:0] LEDR_L,
  output logic [LEDS-1:0] LEDR_R,
  output mode_t           cur_mode
);

  localparam int STEP_W = $clog2(LEDS + 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LEDS);

  mode_t            mode_q;
  logic [STEP_W-1:0] step_q;
  logic             phase_q;

  logic             mode_chg;
  logic             tick;
  logic             brake_s;
  logic [STEP_W-1:0] nxt_step;
  logic             nxt_phase;
  logic [LEDS-1:0]  nxt_l;
  logic [LEDS-1:0]  nxt_r;

`ifdef TAIL_BRAKE_EN
  assign brake_s = brake;
`else
  assign brake_s = 1'b0;
`endif

  // Left-bank pattern for a step (bit 0 innermost).
  function automatic logic [LEDS-1:0] sweep_pat(input logic [STEP_W-1:0] s);
    logic [LEDS-1:0] p;
    for (int i = 0; i < LEDS; i++) begin
      if (FILL != 0)
        p[i] = (STEP_W'(i) < s);
      else
        p[i] = (STEP_W'(i + 1) == s);
    end
    return p;
  endfunction

  // The right bank counts from its outer end, so it is the left pattern mirrored.
  function automatic logic [LEDS-1:0] mirror(input logic [LEDS-1:0] v);
    logic [LEDS-1:0] r;
    for (int i = 0; i < LEDS; i++)
      r[i] = v[LEDS-1-i];
    return r;
  endfunction

  tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mode_chg),
    .tick    (tick)
  );

  assign mode_chg = (mode != mode_q);

  always_comb begin
    nxt_step  = step_q;
    nxt_phase = phase_q;
    if (mode_chg) begin
      nxt_step  = '0;
      nxt_phase = 1'b0;
    end else begin
      case (eff_mode(mode_q))
        MODE_HAZARD: if (tick) nxt_phase = ~phase_q;
        MODE_LEFT, MODE_RIGHT:
          if (tick) nxt_step = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
        default: begin
          nxt_step  = '0;
          nxt_phase = 1'b0;
        end
      endcase
    end

    // LEDs are derived from the next step/phase so they land on the same edge.
    nxt_l = '0;
    nxt_r = '0;
    case (eff_mode(mode))
      MODE_HAZARD: begin
        nxt_l = {LEDS{nxt_phase}};
        nxt_r = {LEDS{nxt_phase}};
      end
      MODE_LEFT: begin
        nxt_l = sweep_pat(nxt_step);
        if (brake_s) nxt_r = '1;
      end
      MODE_RIGHT: begin
        nxt_r = mirror(sweep_pat(nxt_step));
        if (brake_s) nxt_l = '1;
      end
      default: begin
        if (brake_s) begin
          nxt_l = '1;
          nxt_r = '1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_IDLE;
      step_q  <= '0;
      phase_q <= 1'b0;
      LEDR_L  <= '0;
      LEDR_R  <= '0;
    end else begin
      mode_q  <= mode;
      step_q  <= nxt_step;
      phase_q <= nxt_phase;
      LEDR_L  <= nxt_l;
      LEDR_R  <= nxt_r;
    end
  end

  assign cur_mode = mode_q;

endmodule

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

Parametrised tail-light sequencer for the board's turn-signal lab. It takes the selected lighting mode from the controller FSM and drives a left and a right LED bank. Supported modes are idle, hazard flash, left sweep and right sweep. Bank width, step rate and sweep style are set by parameters, and an optional brake overlay is available. It also exports the registered mode for the seven-segment display path.

## Interface
- LEDS, default 3: LEDs per side; legal range 2..16.
- TICK_DIV, default 1: clk cycles per sequence step; legal range 1..2^20.
- FILL, default 0: sweep style; 0 = single walking LED, 1 = cumulative fill.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  3  requested mode: 0 IDLE, 1 HAZARD, 2 LEFT, 3 RIGHT; codes 4..7 behave as IDLE
- brake  in  1  brake request; present only with TAIL_BRAKE_EN
- LEDR_L  out  LEDS  left bank, bit 0 innermost
- LEDR_R  out  LEDS  right bank, bit 0 outermost
- cur_mode  out  3  registered mode (mode_q), feeds the seven-segment decoder

## Operation
- Internal registers:
  - mode_q: registered copy of mode.
  - div_cnt: prescaler, width clog2(TICK_DIV), minimum 1 bit.
  - step: 0..LEDS, width clog2(LEDS+1).
  - phase: 1 bit.
- Tick: asserted in any cycle where div_cnt == TICK_DIV-1. On a tick, div_cnt wraps to 0; otherwise it increments.
- Mode change (mode != mode_q) on a clock edge:
  - mode_q <= mode.
  - div_cnt, step and phase clear to 0.
  - Both banks go to 0, except for the brake overlay.
  - A mode change takes priority over a coincident tick.
- IDLE:
  - Both banks are 0.
  - step and phase are held at 0.
- HAZARD:
  - Each tick toggles phase.
  - phase 1: both banks are all ones. phase 0: both banks are 0.
- LEFT:
  - LEDR_R is 0.
  - Each tick, step advances 0→1→…→LEDS→0.
  - FILL=0: LEDR_L = one-hot bit (step-1), or 0 when step is 0.
  - FILL=1: LEDR_L = (1<<step)-1.
- RIGHT: mirror of LEFT.
  - LEDR_L is 0.
  - FILL=0: LEDR_R = one-hot bit (LEDS-step).
  - FILL=1: LEDR_R = top `step` bits set.
- LED registers update on the same edge as step/phase, so the outputs always reflect the new step value.
- Wrap-around: the edge after step == LEDS returns to step 0 with all LEDs off. The full period is (LEDS+1)·TICK_DIV cycles.
- Mode held unchanged: the sequence runs forever. Re-selecting the same mode does not restart it.

## Timing
- Reset (asynchronous, while reset_n=0): LEDR_L=0, LEDR_R=0, cur_mode=0, mode_q=0, div_cnt=0, step=0, phase=0.
- Reset removal: IDLE. A mode already applied at release is captured on the first edge.
- Mode-to-output latency: 1 clk edge. The first lit step appears TICK_DIV cycles after that edge.
- Reset asserted mid-sequence: everything clears immediately. The sequence always restarts from step 0.
- mode is assumed synchronous to clk; any synchroniser lives upstream.

## Configuration
- TAIL_BRAKE_EN defined:
  - The brake port exists.
  - While brake=1, every bank not currently sweeping is forced to all ones:
    - IDLE: both banks.
    - LEFT: right bank.
    - RIGHT: left bank.
    - HAZARD: brake is ignored.
  - Brake is sampled in the same register stage as the LED outputs, giving 1 cycle latency.
  - Brake never alters step, phase or div_cnt.
- TAIL_BRAKE_EN undefined: no brake port; behaviour is identical to brake=0.

## Structure
- Shared package tail_pkg:
  - Mode encoding constants MODE_IDLE, MODE_HAZARD, MODE_LEFT, MODE_RIGHT.
  - 3-bit mode typedef used by the controller FSM and this block.
- Sub-module tick_div: parametrised prescaler (TICK_DIV) with a synchronous clear input, producing the one-cycle tick pulse.
- The seven-segment decoder stays outside and consumes cur_mode.

## Test plan
- Reset: hold reset_n=0 mid-sweep → all outputs 0 immediately; after release with mode=0, outputs stay 0.
- LEDS=3, TICK_DIV=1, FILL=0, mode=2 → LEDR_L = 000, 001, 010, 100, 000, … on successive edges; LEDR_R=000 throughout.
- LEDS=4, TICK_DIV=3, FILL=1, mode=3 → LEDR_R steps 0000, 1000, 1100, 1110, 1111, 0000, each held 3 cycles; 15-cycle period.
- mode=1, TICK_DIV=2 → both banks alternate: all off for 2 cycles, all ones for 2 cycles; switching to mode=2 mid-on clears both banks on the next edge.
- Switch mode 2→3 while step=2 → next edge: both banks 0 and cur_mode=3; right sweep starts at step 0.
- With TAIL_BRAKE_EN, mode=2, brake=1 → LEDR_R=all ones while LEDR_L keeps sweeping; with mode=1, brake has no effect.
